// File: rtl/branch_unit_pkg.sv
// Shared types and constants for the branch resolution unit.
// Holds the op-kind encoding, the branch funct3 codes and the default
// result record used by the result buffer.
package branch_unit_pkg;

  localparam int BRU_XLEN      = 32;
  localparam int BRU_ROB_IDX_W = 6;
  localparam int BRU_BR_TAG_W  = 4;

  typedef enum logic [1:0] {
    BRU_BR   = 2'b00,
    BRU_JAL  = 2'b01,
    BRU_JALR = 2'b10
  } bru_kind_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Result record for the default configuration (XLEN=32, ROB_IDX_W=6, BR_TAG_W=4).
  typedef struct packed {
    logic [BRU_ROB_IDX_W-1:0] rob;
    logic [BRU_BR_TAG_W-1:0]  br_tag;
    logic [BRU_XLEN-1:0]      rd_val;
    logic                     taken;
    logic [BRU_XLEN-1:0]      target;
    logic                     mispredict;
  } bru_result_t;

endpackage

// File: rtl/bru_result_fifo.sv
// Circular result buffer between the branch exec stage and the CDB.
// Flush has priority over push and pop; reset clears pointers, count and storage.
module bru_result_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!push && pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers, fully cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: resolves BR/JAL/JALR in a single exec stage, flags
// mispredictions and buffers results for the CDB in bru_result_fifo.
// Optional performance counters are enabled with BRANCH_UNIT_PERF_CNT_EN.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int XLEN      = BRU_XLEN,
  parameter int DEPTH     = 4,
  parameter int ROB_IDX_W = BRU_ROB_IDX_W,
  parameter int BR_TAG_W  = BRU_BR_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic [1:0]           iss_kind,
  input  logic [2:0]           iss_cmp_op,
  input  logic [XLEN-1:0]      iss_pc,
  input  logic [XLEN-1:0]      iss_imm,
  input  logic [XLEN-1:0]      iss_a,
  input  logic [XLEN-1:0]      iss_b,
  input  logic                 iss_pred_taken,
  input  logic [XLEN-1:0]      iss_pred_target,
  input  logic [ROB_IDX_W-1:0] iss_rob,
  input  logic [BR_TAG_W-1:0]  iss_br_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROB_IDX_W-1:0] out_rob,
  output logic [BR_TAG_W-1:0]  out_br_tag,
  output logic [XLEN-1:0]      out_rd_val,
  output logic                 out_taken,
  output logic [XLEN-1:0]      out_target,
  output logic                 out_mispredict
`ifdef BRANCH_UNIT_PERF_CNT_EN
  ,
  output logic [31:0]          perf_resolved,
  output logic [31:0]          perf_taken,
  output logic [31:0]          perf_mispredict
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [1:0]           kind;
    logic [2:0]           cmp_op;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic                 pred_taken;
    logic [XLEN-1:0]      pred_target;
    logic [ROB_IDX_W-1:0] rob;
    logic [BR_TAG_W-1:0]  br_tag;
  } exec_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob;
    logic [BR_TAG_W-1:0]  br_tag;
    logic [XLEN-1:0]      rd_val;
    logic                 taken;
    logic [XLEN-1:0]      target;
    logic                 mispredict;
  } res_t;

  function automatic logic br_taken(input logic [2:0] op, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return sa < sb;
      F3_BGE:  return sa >= sb;
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic             accept;
  logic             exec_valid_q, exec_valid_d;
  exec_t            exec_q, exec_d;
  res_t             exec_res;
  logic [XLEN-1:0]  sum_pc;
  logic [XLEN-1:0]  sum_a;
  logic             push;
  logic             pop;
  res_t             fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Ready is conservative: a same-cycle pop is ignored so exec never stalls.
  assign iss_ready = !fifo_full && !(exec_valid_q && (fifo_count == CNT_W'(DEPTH - 1)));
  assign accept    = iss_valid && iss_ready && !flush;

  // Capture an accepted op into the exec register; operand data only moves on accept.
  always_comb begin
    exec_valid_d = accept;
    exec_d       = exec_q;
    if (accept) begin
      exec_d.kind        = iss_kind;
      exec_d.cmp_op      = iss_cmp_op;
      exec_d.pc          = iss_pc;
      exec_d.imm         = iss_imm;
      exec_d.a           = iss_a;
      exec_d.b           = iss_b;
      exec_d.pred_taken  = iss_pred_taken;
      exec_d.pred_target = iss_pred_target;
      exec_d.rob         = iss_rob;
      exec_d.br_tag      = iss_br_tag;
    end
  end

  // Exec register; reset clears data as well so outputs read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_valid_q <= 1'b0;
      exec_q       <= '0;
    end else begin
      exec_valid_q <= exec_valid_d;
      exec_q       <= exec_d;
    end
  end

  // Resolve direction, target, link value and mispredict; kind 11 behaves as a not-taken BR.
  always_comb begin
    sum_pc          = exec_q.pc + exec_q.imm;
    sum_a           = exec_q.a + exec_q.imm;
    exec_res        = '0;
    exec_res.rob    = exec_q.rob;
    exec_res.br_tag = exec_q.br_tag;
    case (exec_q.kind)
      BRU_JAL: begin
        exec_res.taken      = 1'b1;
        exec_res.target     = sum_pc;
        exec_res.rd_val     = exec_q.pc + XLEN'(4);
        exec_res.mispredict = (sum_pc != exec_q.pred_target);
      end
      BRU_JALR: begin
        exec_res.taken      = 1'b1;
        exec_res.target     = {sum_a[XLEN-1:1], 1'b0};
        exec_res.rd_val     = exec_q.pc + XLEN'(4);
        exec_res.mispredict = ({sum_a[XLEN-1:1], 1'b0} != exec_q.pred_target);
      end
      default: begin
        exec_res.taken      = (exec_q.kind == BRU_BR) && br_taken(exec_q.cmp_op, exec_q.a, exec_q.b);
        exec_res.target     = sum_pc;
        exec_res.mispredict = (exec_res.taken != exec_q.pred_taken) ||
                              (exec_res.taken && (sum_pc != exec_q.pred_target));
      end
    endcase
  end

  assign push      = exec_valid_q && !flush;
  assign out_valid = !fifo_empty && !flush;
  assign pop       = out_valid && out_ready;

  bru_result_fifo #(
    .DEPTH (DEPTH),
    .T     (res_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (exec_res),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_rob        = fifo_head.rob;
  assign out_br_tag     = fifo_head.br_tag;
  assign out_rd_val     = fifo_head.rd_val;
  assign out_taken      = fifo_head.taken;
  assign out_target     = fifo_head.target;
  assign out_mispredict = fifo_head.mispredict;

`ifdef BRANCH_UNIT_PERF_CNT_EN
  logic [31:0] perf_resolved_q, perf_resolved_d;
  logic [31:0] perf_taken_q, perf_taken_d;
  logic [31:0] perf_mispredict_q, perf_mispredict_d;

  // Count results as they leave for the CDB; flush does not clear these.
  always_comb begin
    perf_resolved_d   = perf_resolved_q;
    perf_taken_d      = perf_taken_q;
    perf_mispredict_d = perf_mispredict_q;
    if (pop) begin
      perf_resolved_d = perf_resolved_q + 32'd1;
      if (fifo_head.taken)      perf_taken_d      = perf_taken_q + 32'd1;
      if (fifo_head.mispredict) perf_mispredict_d = perf_mispredict_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_resolved_q   <= '0;
      perf_taken_q      <= '0;
      perf_mispredict_q <= '0;
    end else begin
      perf_resolved_q   <= perf_resolved_d;
      perf_taken_q      <= perf_taken_d;
      perf_mispredict_q <= perf_mispredict_d;
    end
  end

  assign perf_resolved   = perf_resolved_q;
  assign perf_taken      = perf_taken_q;
  assign perf_mispredict = perf_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with a queue-based reference model and
// hand-computed literal expectations. Honours BRANCH_UNIT_PERF_CNT_EN.
module tb_branch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        iss_valid;
  logic        iss_ready;
  logic [1:0]  iss_kind;
  logic [2:0]  iss_cmp_op;
  logic [31:0] iss_pc, iss_imm, iss_a, iss_b;
  logic        iss_pred_taken;
  logic [31:0] iss_pred_target;
  logic [5:0]  iss_rob;
  logic [3:0]  iss_br_tag;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_rob;
  logic [3:0]  out_br_tag;
  logic [31:0] out_rd_val;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_mispredict;
`ifdef BRANCH_UNIT_PERF_CNT_EN
  logic [31:0] perf_resolved, perf_taken, perf_mispredict;
`endif

  branch_unit #(.XLEN(32), .DEPTH(DEPTH), .ROB_IDX_W(6), .BR_TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_kind(iss_kind),
    .iss_cmp_op(iss_cmp_op), .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_a(iss_a), .iss_b(iss_b), .iss_pred_taken(iss_pred_taken),
    .iss_pred_target(iss_pred_target), .iss_rob(iss_rob), .iss_br_tag(iss_br_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob),
    .out_br_tag(out_br_tag), .out_rd_val(out_rd_val), .out_taken(out_taken),
    .out_target(out_target), .out_mispredict(out_mispredict)
`ifdef BRANCH_UNIT_PERF_CNT_EN
    , .perf_resolved(perf_resolved), .perf_taken(perf_taken),
    .perf_mispredict(perf_mispredict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [5:0]  rob;
    logic [3:0]  tag;
    logic [31:0] rd;
    logic        taken;
    logic [31:0] tgt;
    logic        mis;
  } mres_t;

  mres_t       mq[$];
  bit          pend_v  = 0;
  mres_t       pend;
  int          acc_cnt = 0;
  logic [31:0] m_res = 0, m_tkn = 0, m_mis = 0;

  function automatic mres_t resolve(input logic [1:0] k, input logic [2:0] op,
                                    input logic [31:0] pc, input logic [31:0] imm,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic pt, input logic [31:0] ptgt,
                                    input logic [5:0] rob, input logic [3:0] tag);
    mres_t  r;
    longint sa, sb;
    sa      = longint'($signed(a));
    sb      = longint'($signed(b));
    r.rob   = rob;
    r.tag   = tag;
    r.rd    = 32'd0;
    r.taken = 1'b0;
    r.tgt   = pc + imm;
    if (k == 2'd1) begin
      r.taken = 1'b1;
      r.rd    = pc + 32'd4;
    end else if (k == 2'd2) begin
      r.taken = 1'b1;
      r.rd    = pc + 32'd4;
      r.tgt   = (a + imm) & 32'hFFFF_FFFE;
    end else if (k == 2'd0) begin
      case (op)
        3'd0: r.taken = (a == b);
        3'd1: r.taken = (a != b);
        3'd4: r.taken = (sa < sb);
        3'd5: r.taken = (sa >= sb);
        3'd6: r.taken = (a < b);
        3'd7: r.taken = (a >= b);
        default: r.taken = 1'b0;
      endcase
    end
    if (k == 2'd1 || k == 2'd2) r.mis = (r.tgt != ptgt);
    else r.mis = (r.taken != pt) || (r.taken && (r.tgt != ptgt));
    return r;
  endfunction

  function automatic bit m_ready();
    return (mq.size() + int'(pend_v)) < DEPTH;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        pend_v = 0;
        m_res  = 0;
        m_tkn  = 0;
        m_mis  = 0;
      end else if (flush) begin
        mq.delete();
        pend_v = 0;
      end else begin
        bit acc;
        acc = iss_valid && m_ready();
        if (mq.size() != 0 && out_ready) begin
          m_res++;
          if (mq[0].taken) m_tkn++;
          if (mq[0].mis)   m_mis++;
          void'(mq.pop_front());
        end
        if (pend_v) mq.push_back(pend);
        pend_v = acc;
        if (acc) begin
          pend = resolve(iss_kind, iss_cmp_op, iss_pc, iss_imm, iss_a, iss_b,
                         iss_pred_taken, iss_pred_target, iss_rob, iss_br_tag);
          acc_cnt++;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        bit exp_ov;
        exp_ov = (mq.size() != 0) && !flush;
        check("m_iss_ready", 32'(iss_ready), 32'(m_ready()));
        check("m_out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
          check("m_rob",    32'(out_rob),        32'(mq[0].rob));
          check("m_tag",    32'(out_br_tag),     32'(mq[0].tag));
          check("m_rd_val", out_rd_val,          mq[0].rd);
          check("m_taken",  32'(out_taken),      32'(mq[0].taken));
          check("m_target", out_target,          mq[0].tgt);
          check("m_mispred", 32'(out_mispredict), 32'(mq[0].mis));
        end
`ifdef BRANCH_UNIT_PERF_CNT_EN
        check("m_perf_res", perf_resolved,   m_res);
        check("m_perf_tkn", perf_taken,      m_tkn);
        check("m_perf_mis", perf_mispredict, m_mis);
`endif
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) iss_valid |-> iss_kind != 2'b11)
    else $error("illegal iss_kind 11 issued");

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [1:0] k, input logic [2:0] op, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                        input logic pt, input logic [31:0] ptgt, input logic [5:0] rob,
                        input logic [3:0] tag);
    iss_kind = k; iss_cmp_op = op; iss_pc = pc; iss_imm = imm; iss_a = a; iss_b = b;
    iss_pred_taken = pt; iss_pred_target = ptgt; iss_rob = rob; iss_br_tag = tag;
  endtask

  task automatic issue(input logic [1:0] k, input logic [2:0] op, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                       input logic pt, input logic [31:0] ptgt, input logic [5:0] rob,
                       input logic [3:0] tag);
    int target;
    set_op(k, op, pc, imm, a, b, pt, ptgt, rob, tag);
    iss_valid = 1'b1;
    target    = acc_cnt + 1;
    for (int t = 0; t < 20 && acc_cnt < target; t++) step();
    if (acc_cnt < target) check("issue_timeout", 32'(acc_cnt), 32'(target));
    iss_valid = 1'b0;
  endtask

  // Issue one op, verify the 2-edge latency and the literal result, then pop it.
  task automatic lit(input string nm, input logic [1:0] k, input logic [2:0] op,
                     input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                     input logic [31:0] b, input logic pt, input logic [31:0] ptgt,
                     input logic [5:0] rob, input logic e_tk, input logic [31:0] e_tgt,
                     input logic [31:0] e_rd, input logic e_mis);
    issue(k, op, pc, imm, a, b, pt, ptgt, rob, 4'(rob));
    @(negedge clk);
    check({nm, "_early_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({nm, "_valid"},  32'(out_valid),      32'd1);
    check({nm, "_rob"},    32'(out_rob),        32'(rob));
    check({nm, "_taken"},  32'(out_taken),      32'(e_tk));
    check({nm, "_target"}, out_target,          e_tgt);
    check({nm, "_rd_val"}, out_rd_val,          e_rd);
    check({nm, "_mispred"}, 32'(out_mispredict), 32'(e_mis));
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b0; flush = 1'b0; iss_valid = 1'b0; out_ready = 1'b0;
    set_op(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0, 4'd0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_iss_ready", 32'(iss_ready), 32'd1);
    check("rst_out_target", out_target, 32'd0);
    check("rst_out_rob", 32'(out_rob), 32'd0);
    check("rst_out_rd_val", out_rd_val, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    lit("beq",     2'd0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120, 6'd1,
        1'b1, 32'h120, 32'h0, 1'b0);
    lit("blt",     2'd0, 3'b100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 6'd2,
        1'b1, 32'h340, 32'h0, 1'b1);
    lit("bltu",    2'd0, 3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 6'd3,
        1'b0, 32'h340, 32'h0, 1'b0);
    lit("jalr",    2'd2, 3'b000, 32'h200, 32'h4, 32'h1003, 32'd0, 1'b0, 32'h1006, 6'd4,
        1'b1, 32'h1006, 32'h204, 1'b0);
    lit("jalr_mp", 2'd2, 3'b000, 32'h200, 32'h4, 32'h1003, 32'd0, 1'b0, 32'h1007, 6'd5,
        1'b1, 32'h1006, 32'h204, 1'b1);
    lit("jal",     2'd1, 3'b000, 32'h400, 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b0, 32'h3F0, 6'd6,
        1'b1, 32'h3F0, 32'h404, 1'b0);
    lit("bge_nt",  2'd0, 3'b101, 32'h500, 32'h8, 32'h8000_0000, 32'd0, 1'b1, 32'h508, 6'd7,
        1'b0, 32'h508, 32'h0, 1'b1);
    lit("op010",   2'd0, 3'b010, 32'h10, 32'h10, 32'd1, 32'd1, 1'b0, 32'h0, 6'd8,
        1'b0, 32'h20, 32'h0, 1'b0);
    lit("bne_tgt", 2'd0, 3'b001, 32'h600, 32'h10, 32'd1, 32'd2, 1'b1, 32'h614, 6'd9,
        1'b1, 32'h610, 32'h0, 1'b1);
    lit("bgeu",    2'd0, 3'b111, 32'h700, 32'hC, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h70C, 6'd10,
        1'b1, 32'h70C, 32'h0, 1'b0);

    // Back-to-back issue with the CDB stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(2'd0, 3'b000, 32'h1000 + 32'(16 * i), 32'd8, 32'(i), 32'(i), 1'b1,
            32'h1008 + 32'(16 * i), 6'(16 + i), 4'(i));
    set_op(2'd1, 3'b000, 32'h1100, 32'h40, 32'd0, 32'd0, 1'b1, 32'h1140, 6'd20, 4'd4);
    iss_valid = 1'b1;
    n0 = acc_cnt;
    repeat (4) step();
    @(negedge clk);
    check("full_iss_ready", 32'(iss_ready), 32'd0);
    check("full_no_accept", 32'(acc_cnt - n0), 32'd0);
    check("full_head_rob", 32'(out_rob), 32'd16);
    @(posedge clk);
    #2 out_ready = 1'b1;
    for (int t = 0; t < 20 && acc_cnt == n0; t++) step();
    check("fifth_accepted", 32'(acc_cnt - n0), 32'd1);
    iss_valid = 1'b0;

    // Ten more ops with an intermittent CDB to walk the pointers round.
    for (int i = 0; i < 10; i++) begin
      out_ready = ((i % 3) != 2);
      issue(2'(i % 3), 3'((i * 5) % 8), 32'h2000 + 32'(4 * i), 32'(8 * i) - 32'd16,
            32'h1111_1111 * 32'(i), 32'h3333_3333, 1'(i), 32'h2000 + 32'(12 * i) - 32'd16,
            6'(30 + i), 4'(i));
    end
    out_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    check("drained_valid", 32'(out_valid), 32'd0);

    // Flush with 3 buffered results plus a concurrent issue and pop.
    @(posedge clk);
    #2 out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(2'd0, 3'b001, 32'h3000, 32'h10, 32'(i), 32'd7, 1'b1, 32'h3010, 6'(40 + i), 4'(i));
    step();
    @(negedge clk);
    check("pre_flush_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
    set_op(2'd1, 3'b000, 32'h4000, 32'h8, 32'd0, 32'd0, 1'b1, 32'h4008, 6'h3F, 4'hF);
    flush = 1'b1; iss_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    step();
    flush = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    check("post_flush_valid", 32'(out_valid), 32'd0);
    check("post_flush_ready", 32'(iss_ready), 32'd1);
    repeat (3) step();
    @(negedge clk);
    check("flushed_op_absent", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle with two results buffered.
    @(posedge clk);
    #2 out_ready = 1'b0;
    issue(2'd1, 3'b000, 32'h5000, 32'h20, 32'd0, 32'd0, 1'b1, 32'h5020, 6'd50, 4'd1);
    issue(2'd0, 3'b000, 32'h5004, 32'h20, 32'd3, 32'd3, 1'b0, 32'h0, 6'd51, 4'd2);
    step();
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_ready", 32'(iss_ready), 32'd1);
    check("rst_async_rob", 32'(out_rob), 32'd0);
`ifdef BRANCH_UNIT_PERF_CNT_EN
    check("rst_perf_res", perf_resolved, 32'd0);
    check("rst_perf_tkn", perf_taken, 32'd0);
    check("rst_perf_mis", perf_mispredict, 32'd0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;

    lit("after_rst", 2'd0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120, 6'd60,
        1'b1, 32'h120, 32'h0, 1'b0);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
